mod_add_ctrl: RTL
=================

# mod_add_ctrl

Sequencer that performs modular addition and subtraction, (A ± B) mod M, on 1027-bit operands by issuing two back-to-back requests to the multi-precision adder. It is the initiator side of the adder's start/subtract/done handshake: it drives the adder's operands, start and subtract, and consumes its result and done. It sits between the exponentiation/Montgomery datapath (upstream) and one external adder instance that shares its clock and reset.

## Interface
- WIDTH, 1027, operand width; must equal the adder's operand width (adder result is WIDTH+1 bits).
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- subtract  in  1  0 = (A+B) mod M, 1 = (A−B) mod M; sampled with start.
- in_a, in_b, in_m  in  WIDTH  operands; sampled with start. Precondition: A < M, B < M, M < 2^(WIDTH−1).
- result  out  WIDTH  modular result; valid from done pulse until next accepted start.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from accepted start through the done cycle.
- adder_start  out  1  one-cycle request to adder.
- adder_subtract  out  1  adder operation select, held with operands.
- adder_in_a, adder_in_b  out  WIDTH  adder operands.
- adder_result  in  WIDTH+1  adder sum/difference; bit WIDTH = carry-out (for subtraction, 1 = no borrow).
- adder_done  in  1  adder completion pulse.

## Operation
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE.
- IDLE: start=1 → latch A, B, M, subtract into internal regs → REQ1. start while not IDLE ignored.
- REQ1: adder_start=1, adder_in_a=A, adder_in_b=B, adder_subtract=subtract → WAIT1.
- WAIT1: on adder_done → latch R1 = adder_result (WIDTH+1 bits).
  - add: → REQ2 with operands (R1[WIDTH−1:0], M), adder_subtract=1.
  - sub, R1[WIDTH]=1 (A ≥ B): result = R1[WIDTH−1:0] → DONE (skip path).
  - sub, R1[WIDTH]=0 (borrow): → REQ2 with operands (R1[WIDTH−1:0], M), adder_subtract=0.
- REQ2: adder_start=1 → WAIT2.
- WAIT2: on adder_done → latch R2.
  - add: result = R2[WIDTH] ? R2[WIDTH−1:0] : R1[WIDTH−1:0].
  - sub: result = R2[WIDTH−1:0] (carry discarded, wrap mod 2^WIDTH).
  - → DONE.
- DONE: done=1 → IDLE.
- adder_in_a/in_b/subtract held stable from REQx through the matching adder_done; adder_done ignored outside WAIT1/WAIT2.
- Precondition violated: completes with unspecified result; never hangs provided adder_done arrives.
- Reset values: state IDLE; done=0, busy=0, adder_start=0, adder_subtract=0; result, adder_in_a, adder_in_b all zero.

## Timing
- L = cycles from the edge sampling adder_start high to the edge sampling adder_done high.
- start sampled at edge 0 → done high in cycle 2L+3 (two-request path), L+2 (skip path).
- start may be asserted in the cycle after done; accepted at next edge.
- adder_start exactly one cycle per request; never two requests without intervening adder_done.
- resetn low mid-operation: next edge returns to IDLE with reset values; no done pulse; adder is reset by the same resetn.
- result changes only in WAIT1 (skip path), WAIT2, or on reset.

## Structure
- Shared package: WIDTH constant, state enumeration, adder handshake port width constants.
- No sub-module: single FSM plus operand/intermediate registers. Adder instantiated by the parent, not inside this block.

## Test plan
- Bench uses behavioural adder model with L=5, WIDTH=1027.
- Add 5+7 mod 11 → result 1, done at cycle 13.
- Add 3+4 mod 11 → result 7 (R2 borrows, R1 selected), done at cycle 13.
- Sub 3−4 mod 11 → result 10, done at cycle 13; sub 9−4 mod 11 → result 5 via skip path, done at cycle 7, exactly one adder_start seen.
- M = 2^1026−1, A = B = M−1, add → result M−2; sub 0−1 mod M → M−1.
- start pulsed during WAIT1 → ignored, single done, result of first request; back-to-back start in cycle after done accepted.
- resetn low during WAIT2 → IDLE next edge, all outputs zero, no done; subsequent 5+7 mod 11 → 1.

Source files
------------

// File: rtl/mod_add_ctrl_pkg.sv
// mod_add_ctrl_pkg: shared width constants and sequencer state encoding
package mod_add_ctrl_pkg;
    localparam int WIDTH     = 1027;
    localparam int ADD_RES_W = WIDTH + 1;
    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE} state_e;
endpackage

// File: rtl/mod_add_ctrl.sv
// mod_add_ctrl: (A +/- B) mod M via two back-to-back requests to an external adder
module mod_add_ctrl
    import mod_add_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 subtract,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH-1:0]     in_m,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output logic                 adder_start,
    output logic                 adder_subtract,
    output logic [WIDTH-1:0]     adder_in_a,
    output logic [WIDTH-1:0]     adder_in_b,
    input  logic [ADD_RES_W-1:0] adder_result,
    input  logic                 adder_done
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d, result_q, result_d;
    logic             sub_q, sub_d, op_sub_q, op_sub_d;
    logic             skip;
    assign skip           = sub_q && adder_result[WIDTH];
    assign adder_start    = (state_q == REQ1) || (state_q == REQ2);
    assign adder_subtract = op_sub_q;
    assign adder_in_a     = a_q;
    assign adder_in_b     = b_q;
    assign result         = result_q;
    assign done           = state_q == DONE;
    assign busy           = state_q != IDLE;
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        sub_d    = sub_q;
        op_sub_d = op_sub_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = REQ1;
                a_d      = in_a;
                b_d      = in_b;
                m_d      = in_m;
                sub_d    = subtract;
                op_sub_d = subtract;
            end
            REQ1: state_d = WAIT1;
            WAIT1: if (adder_done) begin
                // a_q keeps R1's low bits for the final select in WAIT2
                a_d      = adder_result[WIDTH-1:0];
                b_d      = m_q;
                op_sub_d = !sub_q;
                state_d  = skip ? DONE : REQ2;
                result_d = skip ? adder_result[WIDTH-1:0] : result_q;
            end
            REQ2: state_d = WAIT2;
            WAIT2: if (adder_done) begin
                state_d  = DONE;
                result_d = (sub_q || adder_result[WIDTH]) ? adder_result[WIDTH-1:0] : a_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            sub_q    <= 1'b0;
            op_sub_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            sub_q    <= sub_d;
            op_sub_q <= op_sub_d;
            result_q <= result_d;
        end
    end
endmodule
